// File: rtl/hv_rac_scan_rsp_pkg.sv
// Shared HV register-access types and constants for the scan responder.
// The CRC step function is the single definition of the scan CRC polynomial.
package hv_rac_scan_rsp_pkg;

  localparam int REG_AW    = 7;
  localparam int REG_DW    = 8;
  localparam int REG_CRC_W = 8;
  localparam int CRC_IN_W  = 1 + REG_AW + REG_DW;

  localparam logic [REG_CRC_W-1:0] CRC_POLY = 8'h07;

  typedef enum logic {
    SRC_OWT  = 1'b0,
    SRC_SCAN = 1'b1
  } rac_src_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RSP
  } rac_state_e;

  // One MSB-first shift of the CRC register, zero initial value.
  function automatic logic [REG_CRC_W-1:0] crc_step(input logic [REG_CRC_W-1:0] crc,
                                                    input logic bit_in);
    logic fb;
    fb = crc[REG_CRC_W-1] ^ bit_in;
    crc_step = {crc[REG_CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/crc16to8_parallel.sv
// Parallel CRC-8 (poly 0x07, init 0) over a 16-bit word, MSB first.
// Purely combinational; callers register the result.
module crc16to8_parallel
  import hv_rac_scan_rsp_pkg::*;
(
  input  logic [CRC_IN_W-1:0]  data,
  output logic [REG_CRC_W-1:0] crc
);

  always_comb begin
    crc = '0;
    for (int i = CRC_IN_W - 1; i >= 0; i--) begin
      crc = crc_step(crc, data[i]);
    end
  end

endmodule

// File: rtl/hv_rac_scan_rsp.sv
// Register-access responder: arbitrates watchdog scan reads and OWT accesses
// onto one register-file port and returns CRC-protected scan read data.
module hv_rac_scan_rsp
  import hv_rac_scan_rsp_pkg::*;
#(
  parameter int RF_RD_LAT       = 1,
  parameter int SCAN_STARVE_MAX = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wdg_scan_rac_rd_req,
  input  logic [REG_AW-1:0]    i_wdg_scan_rac_addr,
  output logic                 o_rac_wdg_scan_ack,
  output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
  output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
  input  logic                 i_scan_crc_inj,
  input  logic                 i_owt_rac_req,
  input  logic                 i_owt_rac_wr,
  input  logic [REG_AW-1:0]    i_owt_rac_addr,
  input  logic [REG_DW-1:0]    i_owt_rac_wdata,
  output logic                 o_rac_owt_ack,
  output logic [REG_DW-1:0]    o_rac_owt_rdata,
  output logic                 o_rf_rd_en,
  output logic                 o_rf_wr_en,
  output logic [REG_AW-1:0]    o_rf_addr,
  output logic [REG_DW-1:0]    o_rf_wdata,
  input  logic [REG_DW-1:0]    i_rf_rdata
);

  localparam int STW = $clog2(SCAN_STARVE_MAX + 1);
  localparam logic [STW-1:0] STARVE_MAX = STW'(SCAN_STARVE_MAX);
  localparam logic [1:0]     WAIT_INIT  = 2'(RF_RD_LAT - 1);

  rac_state_e          state;
  rac_src_e            src_q;
  logic                wr_q;
  logic [REG_AW-1:0]   addr_q;
  logic [1:0]          wait_cnt;
  logic [STW-1:0]      starve_cnt;
  logic                grant_scan;
  logic                grant_owt;
  logic [REG_CRC_W-1:0] crc_raw;
  logic [REG_CRC_W-1:0] crc_inj_mask;

  always_comb begin
    grant_scan = i_wdg_scan_rac_rd_req && (!i_owt_rac_req || starve_cnt == STARVE_MAX);
    grant_owt  = i_owt_rac_req && !grant_scan;
  end

  assign crc_inj_mask = {{(REG_CRC_W-1){1'b0}}, i_scan_crc_inj};

  // The read data is captured into the output register on the same edge the CRC
  // is registered, so the CRC sees the captured value straight from the RF bus.
  crc16to8_parallel u_crc (
    .data ({1'b1, addr_q, i_rf_rdata}),
    .crc  (crc_raw)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      src_q               <= SRC_OWT;
      wr_q                <= 1'b0;
      addr_q              <= '0;
      wait_cnt            <= '0;
      starve_cnt          <= '0;
      o_rac_wdg_scan_ack  <= 1'b0;
      o_rac_wdg_scan_data <= '0;
      o_rac_wdg_scan_crc  <= '0;
      o_rac_owt_ack       <= 1'b0;
      o_rac_owt_rdata     <= '0;
      o_rf_rd_en          <= 1'b0;
      o_rf_wr_en          <= 1'b0;
      o_rf_addr           <= '0;
      o_rf_wdata          <= '0;
    end else begin
      o_rac_wdg_scan_ack <= 1'b0;
      o_rac_owt_ack      <= 1'b0;
      o_rf_rd_en         <= 1'b0;
      o_rf_wr_en         <= 1'b0;
      case (state)
        IDLE: begin
          if (!i_wdg_scan_rac_rd_req) begin
            starve_cnt <= '0;
          end
          if (grant_scan) begin
            src_q      <= SRC_SCAN;
            wr_q       <= 1'b0;
            addr_q     <= i_wdg_scan_rac_addr;
            o_rf_addr  <= i_wdg_scan_rac_addr;
            o_rf_wdata <= '0;
            o_rf_rd_en <= 1'b1;
            starve_cnt <= '0;
            state      <= ISSUE;
          end else if (grant_owt) begin
            src_q      <= SRC_OWT;
            wr_q       <= i_owt_rac_wr;
            addr_q     <= i_owt_rac_addr;
            o_rf_addr  <= i_owt_rac_addr;
            o_rf_wdata <= i_owt_rac_wdata;
            o_rf_rd_en <= !i_owt_rac_wr;
            o_rf_wr_en <= i_owt_rac_wr;
            if (i_wdg_scan_rac_rd_req && starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_INIT;
          if (wr_q) begin
            o_rac_owt_ack   <= 1'b1;
            o_rac_owt_rdata <= '0;
            state           <= RSP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            if (src_q == SRC_SCAN) begin
              o_rac_wdg_scan_ack  <= 1'b1;
              o_rac_wdg_scan_data <= i_rf_rdata;
              o_rac_wdg_scan_crc  <= crc_raw ^ crc_inj_mask;
            end else begin
              o_rac_owt_ack   <= 1'b1;
              o_rac_owt_rdata <= i_rf_rdata;
            end
            state <= RSP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RSP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_rac_scan_rsp.sv
// Self-checking bench for hv_rac_scan_rsp: a default-latency instance plus an
// RF_RD_LAT=3 instance, each backed by a behavioural register file.
module tb_hv_rac_scan_rsp;
  import hv_rac_scan_rsp_pkg::*;

  typedef struct {
    logic              is_scan;
    logic              wr;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] wdata;
    logic              inj;
    logic [REG_DW-1:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic                 scan_req = 1'b0;
  logic [REG_AW-1:0]    scan_addr = '0;
  logic                 scan_ack;
  logic [REG_DW-1:0]    scan_data;
  logic [REG_CRC_W-1:0] scan_crc;
  logic                 crc_inj = 1'b0;
  logic                 owt_req = 1'b0;
  logic                 owt_wr = 1'b0;
  logic [REG_AW-1:0]    owt_addr = '0;
  logic [REG_DW-1:0]    owt_wdata = '0;
  logic                 owt_ack;
  logic [REG_DW-1:0]    owt_rdata;
  logic                 rf_rd_en;
  logic                 rf_wr_en;
  logic [REG_AW-1:0]    rf_addr;
  logic [REG_DW-1:0]    rf_wdata;
  logic [REG_DW-1:0]    rf_rdata;

  logic                 scan_req3 = 1'b0;
  logic [REG_AW-1:0]    scan_addr3 = '0;
  logic                 scan_ack3;
  logic [REG_DW-1:0]    scan_data3;
  logic [REG_CRC_W-1:0] scan_crc3;
  logic                 owt_ack3;
  logic [REG_DW-1:0]    owt_rdata3;
  logic                 rf_rd_en3;
  logic                 rf_wr_en3;
  logic [REG_AW-1:0]    rf_addr3;
  logic [REG_DW-1:0]    rf_wdata3;
  logic [REG_DW-1:0]    rf_rdata3;
  logic                 tie0 = 1'b0;
  logic [REG_AW-1:0]    tie_addr = '0;
  logic [REG_DW-1:0]    tie_data = '0;

  int checks = 0;
  int failures = 0;

  logic [REG_DW-1:0] mem     [128];
  logic [REG_DW-1:0] ref_mem [128];

  hv_rac_scan_rsp #(.RF_RD_LAT(1), .SCAN_STARVE_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_wdg_scan_rac_rd_req(scan_req), .i_wdg_scan_rac_addr(scan_addr),
    .o_rac_wdg_scan_ack(scan_ack), .o_rac_wdg_scan_data(scan_data),
    .o_rac_wdg_scan_crc(scan_crc), .i_scan_crc_inj(crc_inj),
    .i_owt_rac_req(owt_req), .i_owt_rac_wr(owt_wr), .i_owt_rac_addr(owt_addr),
    .i_owt_rac_wdata(owt_wdata), .o_rac_owt_ack(owt_ack), .o_rac_owt_rdata(owt_rdata),
    .o_rf_rd_en(rf_rd_en), .o_rf_wr_en(rf_wr_en), .o_rf_addr(rf_addr),
    .o_rf_wdata(rf_wdata), .i_rf_rdata(rf_rdata)
  );

  hv_rac_scan_rsp #(.RF_RD_LAT(3), .SCAN_STARVE_MAX(4)) dut3 (
    .i_clk(clk), .i_rst(rst),
    .i_wdg_scan_rac_rd_req(scan_req3), .i_wdg_scan_rac_addr(scan_addr3),
    .o_rac_wdg_scan_ack(scan_ack3), .o_rac_wdg_scan_data(scan_data3),
    .o_rac_wdg_scan_crc(scan_crc3), .i_scan_crc_inj(tie0),
    .i_owt_rac_req(tie0), .i_owt_rac_wr(tie0), .i_owt_rac_addr(tie_addr),
    .i_owt_rac_wdata(tie_data), .o_rac_owt_ack(owt_ack3), .o_rac_owt_rdata(owt_rdata3),
    .o_rf_rd_en(rf_rd_en3), .o_rf_wr_en(rf_wr_en3), .o_rf_addr(rf_addr3),
    .o_rf_wdata(rf_wdata3), .i_rf_rdata(rf_rdata3)
  );

  // Register-file models: data is valid exactly RF_RD_LAT cycles after the read
  // strobe and deliberately inverted in every other cycle.
  logic              p1_v = 1'b0;
  logic [REG_AW-1:0] p1_a = '0;
  logic [2:0]        p3_v = '0;
  logic [REG_AW-1:0] p3_a [3];

  always @(posedge clk) begin
    p1_v <= rf_rd_en;
    p1_a <= rf_addr;
    if (rf_wr_en) mem[rf_addr] <= rf_wdata;
    p3_v <= {p3_v[1:0], rf_rd_en3};
    p3_a[0] <= rf_addr3;
    p3_a[1] <= p3_a[0];
    p3_a[2] <= p3_a[1];
  end

  assign rf_rdata  = p1_v    ? mem[p1_a]    : ~mem[p1_a];
  assign rf_rdata3 = p3_v[2] ? mem[p3_a[2]] : ~mem[p3_a[2]];

  // Remainder of msg * x^8 divided by x^8 + x^2 + x + 1.
  function automatic logic [7:0] crcModel(input logic [15:0] msg);
    logic [23:0] r;
    r = {msg, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (r[i]) r = r ^ (24'h107 << (i - 8));
    end
    return r[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives one request on the default instance and checks timing, acks and data.
  task automatic applyStimulus(input vec_t v, input string tag);
    int rd_c, wr_c, wr_cnt, ack_c, sacks, oacks;
    logic [REG_DW-1:0]    got_data;
    logic [REG_CRC_W-1:0] got_crc;
    rd_c = 0; wr_c = 0; wr_cnt = 0; ack_c = 0; sacks = 0; oacks = 0;
    got_data = '0; got_crc = '0;
    if (v.is_scan) begin
      scan_req = 1'b1; scan_addr = v.addr; crc_inj = v.inj;
    end else begin
      owt_req = 1'b1; owt_wr = v.wr; owt_addr = v.addr; owt_wdata = v.wdata;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rf_rd_en && rd_c == 0) rd_c = c;
      if (rf_wr_en) begin
        wr_cnt++;
        if (wr_c == 0) wr_c = c;
      end
      if (scan_ack) begin
        sacks++;
        if (ack_c == 0 && v.is_scan) begin
          ack_c = c; got_data = scan_data; got_crc = scan_crc;
        end
        scan_req = 1'b0;
      end
      if (owt_ack) begin
        oacks++;
        if (ack_c == 0 && !v.is_scan) begin
          ack_c = c; got_data = owt_rdata;
        end
        owt_req = 1'b0;
      end
      if (ack_c != 0 && c >= ack_c + 3) break;
    end
    scan_req = 1'b0; owt_req = 1'b0; crc_inj = 1'b0;
    checkOutput({tag, "_ack_lat"}, ack_c, (v.is_scan || !v.wr) ? 3 : 2);
    checkOutput({tag, "_issue_cyc"}, v.wr ? wr_c : rd_c, 1);
    checkOutput({tag, "_wr_strobes"}, wr_cnt, (!v.is_scan && v.wr) ? 1 : 0);
    checkOutput({tag, "_scan_acks"}, sacks, v.is_scan ? 1 : 0);
    checkOutput({tag, "_owt_acks"}, oacks, v.is_scan ? 0 : 1);
    checkOutput({tag, "_data"}, got_data, v.exp_data);
    if (v.is_scan) begin
      checkOutput({tag, "_crc"}, got_crc, crcModel({1'b1, v.addr, v.exp_data}) ^ {7'b0, v.inj});
      checkOutput({tag, "_data_hold"}, scan_data, v.exp_data);
    end
    if (!v.is_scan && v.wr) ref_mem[v.addr] = v.wdata;
  endtask

  task automatic waitOwtAcks(input int k, input string tag);
    int n;
    n = 0;
    for (int c = 0; c < 60 && n < k; c++) begin
      @(negedge clk);
      if (owt_ack) n++;
    end
    checkOutput({tag, "_owt_wait"}, n, k);
  endtask

  // OWT is held high; counts OWT acks until the pending scan is finally served.
  task automatic countOwtBeforeScan(input string tag);
    int n;
    logic done;
    n = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (owt_ack) n++;
      if (scan_ack) begin
        done = 1'b1;
        scan_req = 1'b0;
        checkOutput({tag, "_scan_data"}, scan_data, ref_mem[7'h50]);
      end
    end
    checkOutput({tag, "_scan_served"}, done, 1'b1);
    checkOutput({tag, "_owt_before_scan"}, n, 4);
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[7'h50] = 8'hA5;
    mem[7'h00] = 8'h00;
    for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];

    tbl[0] = '{1'b1, 1'b0, 7'h50, 8'h00, 1'b0, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 7'h0B, 8'h3C, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 7'h0B, 8'h00, 1'b0, 8'h3C};
    tbl[3] = '{1'b1, 1'b0, 7'h0B, 8'h00, 1'b0, 8'h3C};
    tbl[4] = '{1'b1, 1'b0, 7'h50, 8'h00, 1'b1, 8'hA5};
    tbl[5] = '{1'b0, 1'b1, 7'h7F, 8'hFF, 1'b0, 8'h00};
    tbl[6] = '{1'b1, 1'b0, 7'h7F, 8'h00, 1'b0, 8'hFF};
    tbl[7] = '{1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 8'h00};

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs",
                {scan_ack, scan_data, scan_crc, owt_ack, owt_rdata, rf_rd_en, rf_wr_en},
                32'h0);
    checkOutput("reset_rf_bus", {rf_addr, rf_wdata}, 32'h0);
    checkOutput("reset_outputs_lat3", {scan_ack3, scan_data3, scan_crc3, rf_rd_en3}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) applyStimulus(tbl[i], $sformatf("vec%0d", i));

    // Starvation: both requesters held high.
    owt_req = 1'b1; owt_wr = 1'b0; owt_addr = 7'h50;
    scan_req = 1'b1; scan_addr = 7'h50;
    countOwtBeforeScan("starve1");
    @(negedge clk);
    scan_req = 1'b1;
    countOwtBeforeScan("starve2");
    // Scan withdrawn before grant clears the starvation history.
    @(negedge clk);
    scan_req = 1'b1;
    waitOwtAcks(2, "withdraw_a");
    scan_req = 1'b0;
    waitOwtAcks(1, "withdraw_b");
    scan_req = 1'b1;
    countOwtBeforeScan("starve3");
    owt_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during WAIT of a scan read.
    begin
      int stray;
      stray = 0;
      scan_req = 1'b1; scan_addr = 7'h50;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_outputs",
                  {scan_ack, scan_data, scan_crc, owt_ack, owt_rdata, rf_rd_en, rf_wr_en},
                  32'h0);
      checkOutput("midrst_rf_bus", {rf_addr, rf_wdata}, 32'h0);
      rst = 1'b0; scan_req = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (scan_ack || owt_ack) stray++;
      end
      checkOutput("midrst_no_ack", stray, 0);
      applyStimulus(tbl[0], "midrst_retry");
    end

    // Randomized traffic against the reference memory.
    for (int i = 0; i < 40; i++) begin
      rv.is_scan = 1'($urandom);
      rv.wr      = !rv.is_scan && 1'($urandom);
      rv.addr    = 7'($urandom);
      rv.wdata   = 8'($urandom);
      rv.inj     = rv.is_scan && ($urandom_range(0, 3) == 0);
      rv.exp_data = rv.wr ? 8'h00 : ref_mem[rv.addr];
      applyStimulus(rv, $sformatf("rnd%0d", i));
    end

    // RF_RD_LAT = 3 instance: two scan reads.
    for (int k = 0; k < 2; k++) begin
      int rd_c, ack_c, acks;
      logic [REG_AW-1:0] a;
      logic [REG_DW-1:0] d;
      logic [REG_CRC_W-1:0] cr;
      a = (k == 0) ? 7'h50 : 7'h0B;
      rd_c = 0; ack_c = 0; acks = 0; d = '0; cr = '0;
      scan_req3 = 1'b1; scan_addr3 = a;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (rf_rd_en3 && rd_c == 0) rd_c = c;
        if (scan_ack3) begin
          acks++;
          if (ack_c == 0) begin
            ack_c = c; d = scan_data3; cr = scan_crc3;
          end
          scan_req3 = 1'b0;
        end
        if (ack_c != 0 && c >= ack_c + 3) break;
      end
      scan_req3 = 1'b0;
      checkOutput($sformatf("lat3_%0d_rd_cyc", k), rd_c, 1);
      checkOutput($sformatf("lat3_%0d_ack_lat", k), ack_c, 5);
      checkOutput($sformatf("lat3_%0d_acks", k), acks, 1);
      checkOutput($sformatf("lat3_%0d_data", k), d, ref_mem[a]);
      checkOutput($sformatf("lat3_%0d_crc", k), cr, crcModel({1'b1, a, ref_mem[a]}));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
